// File: rtl/ble_slot_sequencer_if.sv
// Link-layer controller <-> slot sequencer bus: event configuration in, radio window controls out.
interface ble_slot_sequencer_if #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned CH_W   = 6,
  parameter int unsigned PAIR_W = 8
);
  localparam int unsigned HOP_W = 5;
  localparam int unsigned EVT_W = 16;

  logic              start;
  logic              stop;
  logic              tx_first;
  logic [CNT_W-1:0]  slot_len;
  logic [CNT_W-1:0]  tifs_len;
  logic [PAIR_W-1:0] num_pairs;
  logic              ch_load;
  logic [CH_W-1:0]   ch_init;
  logic [HOP_W-1:0]  hop_inc;

  logic              ble_tx;
  logic              ble_rx;
  logic              ble_tifs;
  logic              busy;
  logic [CH_W-1:0]   channel_index;
  logic              event_done;
  logic              cfg_err;
  logic [EVT_W-1:0]  evt_count;

  modport master (
    output start, stop, tx_first, slot_len, tifs_len, num_pairs, ch_load, ch_init, hop_inc,
    input  ble_tx, ble_rx, ble_tifs, busy, channel_index, event_done, cfg_err, evt_count
  );

  modport slave (
    input  start, stop, tx_first, slot_len, tifs_len, num_pairs, ch_load, ch_init, hop_inc,
    output ble_tx, ble_rx, ble_tifs, busy, channel_index, event_done, cfg_err, evt_count
  );
endinterface

// File: rtl/ble_slot_sequencer.sv
// BLE connection-event slot sequencer: alternating TX/RX slots separated by TIFS gaps, channel hop at event end.
// Optional completed-event counter enabled by macro BLE_SLOT_STATS_EN.
module ble_slot_sequencer #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned CH_W   = 6,
  parameter int unsigned NUM_CH = 37,
  parameter int unsigned PAIR_W = 8
) (
  input  logic                 clock,
  input  logic                 rst,
  ble_slot_sequencer_if.slave  bus
);
  localparam int unsigned HOP_W = 5;
  localparam int unsigned SUM_W = CH_W + 1;
  localparam int unsigned EVT_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_SLOT, S_GAP} state_e;

  state_e            state_q, state_d;
  logic              cur_tx_q, cur_tx_d;
  logic              second_q, second_d;
  logic              stop_req_q, stop_req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PAIR_W-1:0] pair_q, pair_d;
  logic [CNT_W-1:0]  slot_len_q, slot_len_d;
  logic [CNT_W-1:0]  tifs_len_q, tifs_len_d;
  logic [PAIR_W-1:0] num_pairs_q, num_pairs_d;
  logic [HOP_W-1:0]  hop_q, hop_d;
  logic [CH_W-1:0]   ch_q, ch_d;

  logic ble_tx_q, ble_tx_d;
  logic ble_rx_q, ble_rx_d;
  logic ble_tifs_q, ble_tifs_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic cfg_err_q, cfg_err_d;

  logic              cfg_ok;
  logic              slot_end;
  logic              gap_end;
  logic              stop_seen;
  logic              event_end;
  logic              cfg_bad;
  logic [PAIR_W-1:0] pair_nxt;
  logic [SUM_W-1:0]  ch_sum;
  logic [CH_W-1:0]   ch_hop;

  assign cfg_ok    = (bus.slot_len != '0) && (bus.tifs_len != '0) && (32'(bus.hop_inc) < NUM_CH);
  assign slot_end  = (cnt_q == slot_len_q - CNT_W'(1));
  assign gap_end   = (cnt_q == tifs_len_q - CNT_W'(1));
  assign stop_seen = stop_req_q | bus.stop;
  assign pair_nxt  = second_q ? pair_q + PAIR_W'(1) : pair_q;

  // Modular hop: a single conditional subtract suffices since both operands are below NUM_CH.
  assign ch_sum = SUM_W'(ch_q) + SUM_W'(hop_q);
  assign ch_hop = (ch_sum >= SUM_W'(NUM_CH)) ? CH_W'(ch_sum - SUM_W'(NUM_CH)) : CH_W'(ch_sum);

  // State register
  always_ff @(posedge clock) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    cur_tx_d    = cur_tx_q;
    second_d    = second_q;
    stop_req_d  = stop_req_q;
    cnt_d       = cnt_q;
    pair_d      = pair_q;
    slot_len_d  = slot_len_q;
    tifs_len_d  = tifs_len_q;
    num_pairs_d = num_pairs_q;
    hop_d       = hop_q;
    ch_d        = ch_q;
    event_end   = 1'b0;
    cfg_bad     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stop_req_d = 1'b0;
        if (bus.start) begin
          if (cfg_ok) begin
            slot_len_d  = bus.slot_len;
            tifs_len_d  = bus.tifs_len;
            num_pairs_d = bus.num_pairs;
            hop_d       = bus.hop_inc;
            cur_tx_d    = bus.tx_first;
            second_d    = 1'b0;
            cnt_d       = '0;
            pair_d      = '0;
            if (bus.ch_load) ch_d = bus.ch_init;
            state_d = S_SLOT;
          end else begin
            cfg_bad = 1'b1;
          end
        end
      end
      S_SLOT: begin
        stop_req_d = stop_seen;
        if (slot_end) begin
          cnt_d  = '0;
          pair_d = pair_nxt;
          if (stop_seen || ((num_pairs_q != '0) && (pair_nxt == num_pairs_q))) begin
            state_d    = S_IDLE;
            stop_req_d = 1'b0;
            ch_d       = ch_hop;
            event_end  = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        stop_req_d = stop_seen;
        if (gap_end) begin
          cnt_d    = '0;
          cur_tx_d = ~cur_tx_q;
          second_d = ~second_q;
          state_d  = S_SLOT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from next state so windows appear the cycle after the deciding edge
  always_comb begin
    ble_tx_d   = 1'b0;
    ble_rx_d   = 1'b0;
    ble_tifs_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = event_end;
    cfg_err_d  = cfg_bad;
    unique case (state_d)
      S_SLOT: begin
        ble_tx_d = cur_tx_d;
        ble_rx_d = ~cur_tx_d;
        busy_d   = 1'b1;
      end
      S_GAP: begin
        ble_tifs_d = 1'b1;
        busy_d     = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clock) begin
    if (!rst) begin
      cur_tx_q    <= 1'b0;
      second_q    <= 1'b0;
      stop_req_q  <= 1'b0;
      cnt_q       <= '0;
      pair_q      <= '0;
      slot_len_q  <= '0;
      tifs_len_q  <= '0;
      num_pairs_q <= '0;
      hop_q       <= '0;
      ch_q        <= '0;
      ble_tx_q    <= 1'b0;
      ble_rx_q    <= 1'b0;
      ble_tifs_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cur_tx_q    <= cur_tx_d;
      second_q    <= second_d;
      stop_req_q  <= stop_req_d;
      cnt_q       <= cnt_d;
      pair_q      <= pair_d;
      slot_len_q  <= slot_len_d;
      tifs_len_q  <= tifs_len_d;
      num_pairs_q <= num_pairs_d;
      hop_q       <= hop_d;
      ch_q        <= ch_d;
      ble_tx_q    <= ble_tx_d;
      ble_rx_q    <= ble_rx_d;
      ble_tifs_q  <= ble_tifs_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

`ifdef BLE_SLOT_STATS_EN
  logic [EVT_W-1:0] evt_cnt_q;

  // Completed-event counter, wraps naturally
  always_ff @(posedge clock) begin
    if (!rst)          evt_cnt_q <= '0;
    else if (done_d)   evt_cnt_q <= evt_cnt_q + EVT_W'(1);
  end

  assign bus.evt_count = evt_cnt_q;
`else
  assign bus.evt_count = '0;
`endif

  assign bus.ble_tx        = ble_tx_q;
  assign bus.ble_rx        = ble_rx_q;
  assign bus.ble_tifs      = ble_tifs_q;
  assign bus.busy          = busy_q;
  assign bus.channel_index = ch_q;
  assign bus.event_done    = done_q;
  assign bus.cfg_err       = cfg_err_q;
endmodule

// File: tb/tb_ble_slot_sequencer.sv
// Self-checking bench for ble_slot_sequencer: vector table of event configs plus an event scoreboard.
module tb_ble_slot_sequencer;
  localparam int NUM_CH = 37;
`ifdef BLE_SLOT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clock = 1'b0;
  logic rst   = 1'b0;
  always #5 clock = ~clock;

  ble_slot_sequencer_if bus ();
  ble_slot_sequencer dut (.clock(clock), .rst(rst), .bus(bus));

  typedef struct {
    bit tx_first; int slot_len; int tifs_len; int num_pairs;
    bit ch_load;  int ch_init;  int hop;
    bit exp_err;  int exp_busy; int exp_ch;
  } vec_t;

  typedef struct {
    int busy; int tx; int rx; int tifs; int first_tx; int first_len; int ch;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int m_ch   = 0;
  int m_evt  = 0;
  bit mon_en = 1'b0;

  int acc_busy, acc_tx, acc_rx, acc_tifs, first_len;
  bit started, first_tx, first_end, bad_flag, prev_done;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: accumulate the window profile of each event, compare at event_done
  always @(negedge clock) begin
    if (!mon_en) begin
      acc_busy = 0; acc_tx = 0; acc_rx = 0; acc_tifs = 0; first_len = 0;
      started = 0; first_tx = 0; first_end = 0; bad_flag = 0; prev_done = 0;
    end else begin
      if ((int'(bus.ble_tx) + int'(bus.ble_rx) + int'(bus.ble_tifs)) > 1) bad_flag = 1;
      if (!bus.busy && (bus.ble_tx || bus.ble_rx || bus.ble_tifs)) bad_flag = 1;
      if (prev_done && bus.event_done) bad_flag = 1;
      prev_done = bus.event_done;
      if (bus.busy) begin
        acc_busy++;
        if (bus.ble_tx)   acc_tx++;
        if (bus.ble_rx)   acc_rx++;
        if (bus.ble_tifs) acc_tifs++;
        if (!started) begin started = 1; first_tx = bus.ble_tx; end
        if (!first_end) begin
          if ((first_tx && bus.ble_tx) || (!first_tx && bus.ble_rx)) first_len++;
          else first_end = 1;
        end
      end
      if (bus.event_done) begin
        chk("done_expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("busy_cycles", acc_busy, e.busy);
          chk("tx_cycles", acc_tx, e.tx);
          chk("rx_cycles", acc_rx, e.rx);
          chk("tifs_cycles", acc_tifs, e.tifs);
          chk("first_role_tx", int'(first_tx), e.first_tx);
          chk("first_slot_len", first_len, e.first_len);
          chk("channel_at_done", int'(bus.channel_index), e.ch);
          chk("busy_at_done", int'(bus.busy), 0);
          chk("exclusion_ok", int'(bad_flag), 0);
          m_evt++;
        end
        acc_busy = 0; acc_tx = 0; acc_rx = 0; acc_tifs = 0; first_len = 0;
        started = 0; first_end = 0; bad_flag = 0;
      end
    end
  end

  task automatic drive_cfg(input vec_t v);
    bus.tx_first  = v.tx_first;
    bus.slot_len  = 16'(v.slot_len);
    bus.tifs_len  = 16'(v.tifs_len);
    bus.num_pairs = 8'(v.num_pairs);
    bus.ch_load   = v.ch_load;
    bus.ch_init   = 6'(v.ch_init);
    bus.hop_inc   = 5'(v.hop);
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (sb.size() == 0 && !bus.busy) return;
    end
    chk({name, "_timeout"}, int'(sb.size()), 0);
  endtask

  task automatic apply(input vec_t v, input string name);
    exp_t e;
    @(negedge clock);
    drive_cfg(v);
    bus.start = 1'b1;
    if (!v.exp_err) begin
      e.busy = v.exp_busy; e.tx = v.slot_len * v.num_pairs; e.rx = v.slot_len * v.num_pairs;
      e.tifs = (2 * v.num_pairs - 1) * v.tifs_len; e.first_tx = int'(v.tx_first);
      e.first_len = v.slot_len; e.ch = v.exp_ch;
      sb.push_back(e);
    end
    @(negedge clock);
    bus.start = 1'b0;
    chk({name, "_cfg_err"}, int'(bus.cfg_err), int'(v.exp_err));
    chk({name, "_busy_latency"}, int'(bus.busy), int'(!v.exp_err));
    if (!v.exp_err) begin
      chk({name, "_role_latency"}, int'(bus.ble_tx), int'(v.tx_first));
      m_ch = v.exp_ch;
    end else begin
      @(negedge clock);
      chk({name, "_cfg_err_pulse"}, int'(bus.cfg_err), 0);
      chk({name, "_idle_after_err"}, int'(bus.busy), 0);
    end
    wait_idle(5000, name);
  endtask

  vec_t vecs[8];

  initial begin
    exp_t e;
    int dones;
    bus.start = 0; bus.stop = 0; bus.tx_first = 0; bus.slot_len = 0; bus.tifs_len = 0;
    bus.num_pairs = 0; bus.ch_load = 0; bus.ch_init = 0; bus.hop_inc = 0;

    vecs[0] = '{1'b1, 625, 150, 1, 1'b1,  5,  7, 1'b0, 1400, 12};
    vecs[1] = '{1'b0,   4,   2, 2, 1'b1,  0,  3, 1'b0,   22,  3};
    vecs[2] = '{1'b1,   3,   1, 1, 1'b1, 33, 10, 1'b0,    7,  6};
    vecs[3] = '{1'b1,   0,   3, 1, 1'b1,  2,  3, 1'b1,    0,  0};
    vecs[4] = '{1'b0,   4,   0, 1, 1'b1,  2,  3, 1'b1,    0,  0};
    vecs[5] = '{1'b0,   5,   2, 1, 1'b0,  0, 10, 1'b0,   12, 16};
    vecs[6] = '{1'b1,   1,   1, 3, 1'b1, 36,  1, 1'b0,   11,  0};
    vecs[7] = '{1'b0,   2,   5, 1, 1'b1, 30, 31, 1'b0,    9, 24};

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_outputs", int'({bus.ble_tx, bus.ble_rx, bus.ble_tifs, bus.event_done, bus.cfg_err}), 0);
    chk("rst_channel", int'(bus.channel_index), 0);
    rst = 1'b1;

    // Reset during a TX slot: everything clears next cycle, no event_done afterwards
    drive_cfg('{1'b1, 20, 2, 1, 1'b1, 9, 3, 1'b0, 0, 0});
    @(negedge clock); bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    repeat (4) @(negedge clock);
    chk("mid_tx_active", int'(bus.ble_tx), 1);
    chk("mid_channel_loaded", int'(bus.channel_index), 9);
    rst = 1'b0;
    @(negedge clock);
    chk("midrst_windows", int'({bus.ble_tx, bus.ble_rx, bus.ble_tifs, bus.busy}), 0);
    chk("midrst_channel", int'(bus.channel_index), 0);
    chk("midrst_flags", int'({bus.event_done, bus.cfg_err}), 0);
    chk("midrst_evt_count", int'(bus.evt_count), 0);
    @(negedge clock);
    rst = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.event_done || bus.busy) dones++;
    end
    chk("midrst_no_done", dones, 0);
    m_ch = 0;
    m_evt = 0;

    mon_en = 1'b1;
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Stop mid-gap: gap completes, one more slot, then event ends; start while busy is ignored
    drive_cfg('{1'b1, 10, 3, 0, 1'b0, 0, 4, 1'b0, 0, 0});
    e = '{23, 10, 10, 3, 1, 10, (m_ch + 4) % NUM_CH};
    sb.push_back(e);
    @(negedge clock); bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    for (int i = 0; i < 100 && !bus.ble_tifs; i++) @(negedge clock);
    chk("stop_gap_reached", int'(bus.ble_tifs), 1);
    bus.stop = 1'b1;
    bus.start = 1'b1;
    bus.slot_len = 16'd0;
    @(negedge clock);
    bus.stop = 1'b0;
    bus.start = 1'b0;
    @(negedge clock);
    chk("start_while_busy_no_err", int'(bus.cfg_err), 0);
    chk("start_while_busy_still_gap", int'(bus.ble_tifs), 1);
    m_ch = e.ch;
    wait_idle(500, "stop");
    @(negedge clock);
    chk("stop_idle_after", int'(bus.busy), 0);

    chk("evt_count", int'(bus.evt_count), STATS ? m_evt : 0);
    chk("sb_drained", int'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
